dfi_init_seq: RTL and testbench

// - Sits on the DFI between the memory controller and the DDR PHY. Owns the DFI after reset.
// - Drives reset_n/cke timing, then issues NumMr mode-register writes (MRW) on phase 0.
// - Once done, passes the controller's 8-phase DFI command/write bundle straight to the PHY.
// - A restart pulse (from a CSR) re-runs the whole sequence.

---
 rtl/dfi_seq_pkg.sv | 55 +++++
 rtl/dfi_init_seq.sv | 124 ++++++++++++
 tb/tb_dfi_init_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dfi_seq_pkg.sv
// Shared DFI command bundle, MRW config entry and init FSM encoding for the
// DFI init sequencer.
package dfi_seq_pkg;

    typedef struct packed {
        logic [16:0] address;
        logic [5:0]  bank;
        logic        cs_n;
        logic        ras_n;
        logic        cas_n;
        logic        we_n;
        logic        act_n;
        logic        cke;
        logic        reset_n;
        logic        odt;
        logic        mode_2n;
        logic [31:0] wrdata;
        logic        wrdata_en;
        logic [3:0]  wrdata_mask;
        logic        rddata_en;
    } dfi_cmd_t;

    typedef struct packed {
        logic [5:0]  bank;
        logic [16:0] value;
    } mr_cfg_t;

    typedef enum logic [2:0] {
        INIT_RESET_HOLD = 3'd0,
        INIT_CKE_WAIT   = 3'd1,
        INIT_XPR        = 3'd2,
        INIT_MRW        = 3'd3,
        INIT_MRD        = 3'd4,
        INIT_DONE       = 3'd5
    } init_state_e;

    localparam dfi_cmd_t DFI_NOP = '{
        address:     17'd0,
        bank:        6'd0,
        cs_n:        1'b1,
        ras_n:       1'b1,
        cas_n:       1'b1,
        we_n:        1'b1,
        act_n:       1'b1,
        cke:         1'b0,
        reset_n:     1'b0,
        odt:         1'b0,
        mode_2n:     1'b0,
        wrdata:      32'd0,
        wrdata_en:   1'b0,
        wrdata_mask: 4'd0,
        rddata_en:   1'b0
    };

endpackage

// File: rtl/dfi_init_seq.sv
// DDR bring-up sequencer: owns the DFI after reset, drives reset_n/cke timing
// and the MRW list, then hands the controller's command bundle to the PHY.
module dfi_init_seq
    import dfi_seq_pkg::*;
#(
    parameter int unsigned NPhases = 8,
    parameter int unsigned NumMr   = 4,
    parameter int unsigned TReset  = 200,
    parameter int unsigned TInit   = 2000,
    parameter int unsigned TXpr    = 20,
    parameter int unsigned TMrd    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      restart_i,
    input  mr_cfg_t  [NumMr-1:0]      mr_cfg_i,
    input  dfi_cmd_t [NPhases-1:0]    ctrl_dfi_i,
    output dfi_cmd_t [NPhases-1:0]    phy_dfi_o,
    output logic                      init_done_o,
    output logic [2:0]                init_state_o
);

    localparam int unsigned TMax01 = (TReset > TInit) ? TReset : TInit;
    localparam int unsigned TMax23 = (TXpr > TMrd) ? TXpr : TMrd;
    localparam int unsigned TMax   = (TMax01 > TMax23) ? TMax01 : TMax23;
    localparam int unsigned TW     = $clog2(TMax + 1);
    localparam int unsigned IdxW   = (NumMr > 1) ? $clog2(NumMr) : 1;

    init_state_e               state_q, state_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    dfi_cmd_t [NPhases-1:0]    phy_dfi_q, phy_dfi_d;
    logic                      init_done_q, init_done_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= INIT_RESET_HOLD;
            timer_q     <= TW'(TReset - 1);
            idx_q       <= '0;
            phy_dfi_q   <= {NPhases{DFI_NOP}};
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            phy_dfi_q   <= phy_dfi_d;
            init_done_q <= init_done_d;
        end
    end

    // Timer is reloaded with T-1 on entry; a state exits once it sits at zero.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = (timer_q != '0) ? timer_q - 1'b1 : timer_q;

        case (state_q)
            INIT_RESET_HOLD: if (timer_q == '0) begin
                state_d = INIT_CKE_WAIT;
                timer_d = TW'(TInit - 1);
            end
            INIT_CKE_WAIT: if (timer_q == '0) begin
                state_d = INIT_XPR;
                timer_d = TW'(TXpr - 1);
            end
            INIT_XPR: if (timer_q == '0) begin
                state_d = INIT_MRW;
            end
            INIT_MRW: begin
                state_d = INIT_MRD;
                timer_d = TW'(TMrd - 1);
            end
            INIT_MRD: if (timer_q == '0) begin
                if (idx_q == IdxW'(NumMr - 1)) begin
                    state_d = INIT_DONE;
                end else begin
                    state_d = INIT_MRW;
                    idx_d   = idx_q + 1'b1;
                end
            end
            INIT_DONE: ;
            default: begin
                state_d = INIT_RESET_HOLD;
                timer_d = TW'(TReset - 1);
                idx_d   = '0;
            end
        endcase

        if (restart_i) begin
            state_d = INIT_RESET_HOLD;
            timer_d = TW'(TReset - 1);
            idx_d   = '0;
        end
    end

    // Outputs are decoded from the next state so the registered bundle lines up with state_q.
    always_comb begin
        phy_dfi_d   = {NPhases{DFI_NOP}};
        init_done_d = (state_d == INIT_DONE);

        if (state_d == INIT_DONE) begin
            phy_dfi_d = ctrl_dfi_i;
        end else begin
            for (int p = 0; p < NPhases; p++) begin
                phy_dfi_d[p].reset_n = (state_d != INIT_RESET_HOLD);
                phy_dfi_d[p].cke     = (state_d == INIT_XPR) || (state_d == INIT_MRW) ||
                                       (state_d == INIT_MRD);
            end
            if (state_d == INIT_MRW) begin
                phy_dfi_d[0].cs_n    = 1'b0;
                phy_dfi_d[0].ras_n   = 1'b0;
                phy_dfi_d[0].cas_n   = 1'b0;
                phy_dfi_d[0].we_n    = 1'b0;
                phy_dfi_d[0].bank    = mr_cfg_i[idx_d].bank;
                phy_dfi_d[0].address = mr_cfg_i[idx_d].value;
            end
        end
    end

    assign phy_dfi_o    = phy_dfi_q;
    assign init_done_o  = init_done_q;
    assign init_state_o = state_q;

endmodule

// File: tb/tb_dfi_init_seq.sv
// Scoreboard bench for dfi_init_seq: a cycle-level sequence model pushes the
// expected outputs for every driven cycle, popped one cycle later and compared.
module tb_dfi_init_seq;
    import dfi_seq_pkg::*;

    localparam int NPH = 8;
    localparam int NMR = 2;
    localparam int TR  = 3;
    localparam int TI  = 5;
    localparam int TX  = 2;
    localparam int TM  = 2;
    localparam int VW  = NPH * $bits(dfi_cmd_t);

    typedef dfi_cmd_t [NPH-1:0] dfi_vec_t;
    typedef struct {
        logic [2:0] state;
        logic       done;
        dfi_vec_t   dfi;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                restart_i;
    mr_cfg_t [NMR-1:0]   mrCfg;
    dfi_vec_t            ctrlDfi;
    dfi_vec_t            phyDfi;
    logic                initDone;
    logic [2:0]          initState;

    int          total = 0;
    int          bad   = 0;
    exp_t        expQ[$];
    init_state_e mState;
    int          mEl;
    int          mIdx;
    dfi_cmd_t    nopCmd;

    always #5 clk = ~clk;

    dfi_init_seq #(
        .NPhases (NPH),
        .NumMr   (NMR),
        .TReset  (TR),
        .TInit   (TI),
        .TXpr    (TX),
        .TMrd    (TM)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .restart_i    (restart_i),
        .mr_cfg_i     (mrCfg),
        .ctrl_dfi_i   (ctrlDfi),
        .phy_dfi_o    (phyDfi),
        .init_done_o  (initDone),
        .init_state_o (initState)
    );

    task automatic checkOutput(input string tag, input logic [VW-1:0] actual,
                               input logic [VW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic int stateLen(input init_state_e s);
        case (s)
            INIT_RESET_HOLD: return TR;
            INIT_CKE_WAIT:   return TI;
            INIT_XPR:        return TX;
            INIT_MRW:        return 1;
            INIT_MRD:        return TM;
            default:         return 0;
        endcase
    endfunction

    function automatic dfi_vec_t expectDfi(input init_state_e s, input int idx, input dfi_vec_t ctrl);
        dfi_vec_t v;
        if (s == INIT_DONE) return ctrl;
        for (int p = 0; p < NPH; p++) begin
            v[p]         = nopCmd;
            v[p].reset_n = (s != INIT_RESET_HOLD);
            v[p].cke     = (s == INIT_XPR || s == INIT_MRW || s == INIT_MRD);
        end
        if (s == INIT_MRW) begin
            v[0].cs_n    = 1'b0;
            v[0].ras_n   = 1'b0;
            v[0].cas_n   = 1'b0;
            v[0].we_n    = 1'b0;
            v[0].bank    = mrCfg[idx].bank;
            v[0].address = mrCfg[idx].value;
        end
        return v;
    endfunction

    function automatic dfi_vec_t randCtrl();
        dfi_vec_t    v;
        logic [95:0] r;
        for (int p = 0; p < NPH; p++) begin
            r    = {$urandom(), $urandom(), $urandom()};
            v[p] = r[$bits(dfi_cmd_t)-1:0];
        end
        v[5].rddata_en = 1'b1;
        v[5].address   = 17'h1ABC;
        return v;
    endfunction

    // Model counts whole cycles spent in each state and moves on after its length.
    task automatic modelStep(input logic rstN, input logic restart);
        if (!rstN || restart) begin
            mState = INIT_RESET_HOLD;
            mEl    = 0;
            mIdx   = 0;
        end else if (mState != INIT_DONE) begin
            mEl++;
            if (mEl == stateLen(mState)) begin
                mEl = 0;
                case (mState)
                    INIT_RESET_HOLD: mState = INIT_CKE_WAIT;
                    INIT_CKE_WAIT:   mState = INIT_XPR;
                    INIT_XPR:        mState = INIT_MRW;
                    INIT_MRW:        mState = INIT_MRD;
                    default: begin
                        if (mIdx == NMR - 1) mState = INIT_DONE;
                        else begin
                            mIdx++;
                            mState = INIT_MRW;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic checkPending();
        exp_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("state", VW'(initState), VW'(e.state));
            checkOutput("done", VW'(initDone), VW'(e.done));
            checkOutput("dfi", VW'(phyDfi), VW'(e.dfi));
        end
    endtask

    task automatic applyStimulus(input logic rstN, input logic restart, input dfi_vec_t ctrl);
        exp_t e;
        @(negedge clk);
        checkPending();
        rst_ni    = rstN;
        restart_i = restart;
        ctrlDfi   = ctrl;
        modelStep(rstN, restart);
        e.state = mState;
        e.done  = (mState == INIT_DONE);
        e.dfi   = expectDfi(mState, mIdx, ctrl);
        expQ.push_back(e);
    endtask

    task automatic runUntil(input string tag, input init_state_e s, input int idx,
                            input int el, input int budget);
        int n = 0;
        while (!(mState == s && mIdx == idx && mEl == el) && n < budget) begin
            applyStimulus(1'b1, 1'b0, randCtrl());
            n++;
        end
        checkOutput(tag, VW'(mState == s && mIdx == idx && mEl == el), VW'(1));
    endtask

    initial begin
        int       rstRise, ckeRise, mrwFirst, doneRise, mrwCount;
        logic [5:0]  mrwBank;
        logic [16:0] mrwAddr;
        dfi_vec_t c;

        nopCmd = '{address: 17'd0, bank: 6'd0, cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1,
                   we_n: 1'b1, act_n: 1'b1, cke: 1'b0, reset_n: 1'b0, odt: 1'b0,
                   mode_2n: 1'b0, wrdata: 32'd0, wrdata_en: 1'b0, wrdata_mask: 4'd0,
                   rddata_en: 1'b0};
        mrCfg[0]  = '{bank: 6'd1, value: 17'h00024};
        mrCfg[1]  = '{bank: 6'd2, value: 17'h1ABCD};
        rst_ni    = 1'b0;
        restart_i = 1'b0;
        ctrlDfi   = randCtrl();
        mState    = INIT_RESET_HOLD;
        mEl       = 0;
        mIdx      = 0;

        applyStimulus(1'b0, 1'b0, randCtrl());
        applyStimulus(1'b0, 1'b0, randCtrl());

        // Bring-up timing and MRW encoding, measured directly on the PHY side.
        rstRise = -1; ckeRise = -1; mrwFirst = -1; doneRise = -1; mrwCount = 0;
        mrwBank = '0; mrwAddr = '0;
        for (int k = 0; k < 24; k++) begin
            applyStimulus(1'b1, 1'b0, randCtrl());
            if (rstRise < 0 && phyDfi[0].reset_n) rstRise = k;
            if (ckeRise < 0 && phyDfi[0].cke) ckeRise = k;
            if (!initDone && !phyDfi[0].cs_n) begin
                mrwCount++;
                if (mrwFirst < 0) begin
                    mrwFirst = k;
                    mrwBank  = phyDfi[0].bank;
                    mrwAddr  = phyDfi[0].address;
                end
            end
            if (doneRise < 0 && initDone) doneRise = k;
        end
        checkOutput("rstLowCycles", VW'(rstRise), VW'(3));
        checkOutput("ckeDelay", VW'(ckeRise - rstRise), VW'(5));
        checkOutput("xprToMrw", VW'(mrwFirst - ckeRise), VW'(2));
        checkOutput("mrwToDone", VW'(doneRise - mrwFirst), VW'(6));
        checkOutput("mrwCount", VW'(mrwCount), VW'(2));
        checkOutput("mrw0Bank", VW'(mrwBank), VW'(1));
        checkOutput("mrw0Addr", VW'(mrwAddr), VW'(17'h24));

        // Pass-through in DONE.
        c = randCtrl();
        applyStimulus(1'b1, 1'b0, c);
        applyStimulus(1'b1, 1'b0, randCtrl());
        checkOutput("pt5Rd", VW'(phyDfi[5].rddata_en), VW'(1));
        checkOutput("pt5Addr", VW'(phyDfi[5].address), VW'(17'h1ABC));

        // Restart from DONE.
        applyStimulus(1'b1, 1'b1, randCtrl());
        applyStimulus(1'b1, 1'b0, randCtrl());
        checkOutput("rstartRn", VW'(phyDfi[0].reset_n), VW'(0));
        checkOutput("rstartDone", VW'(initDone), VW'(0));

        // Restart while still holding reset extends the hold.
        applyStimulus(1'b1, 1'b1, randCtrl());

        // Restart in MRD of the second MRW.
        runUntil("reachMrd1", INIT_MRD, 1, 0, 60);
        applyStimulus(1'b1, 1'b1, randCtrl());
        applyStimulus(1'b1, 1'b0, randCtrl());
        checkOutput("mrdRstartRn", VW'(phyDfi[0].reset_n), VW'(0));

        // Restart coinciding with the MRD->DONE transition.
        runUntil("reachLastMrd", INIT_MRD, 1, TM - 1, 60);
        applyStimulus(1'b1, 1'b1, randCtrl());
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, randCtrl());
            checkOutput("noDone", VW'(initState == 3'd5), VW'(0));
        end

        // Synchronous reset mid-CKE_WAIT.
        runUntil("reachCkeWait", INIT_CKE_WAIT, 0, 2, 60);
        applyStimulus(1'b0, 1'b0, randCtrl());
        applyStimulus(1'b1, 1'b0, randCtrl());
        checkOutput("midRstState", VW'(initState), VW'(0));
        checkOutput("midRstDfi", VW'(phyDfi), VW'({NPH{nopCmd}}));

        runUntil("reachDone", INIT_DONE, NMR - 1, 0, 60);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, randCtrl());
        @(negedge clk);
        checkPending();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
